// File: rtl/debounce_pkg.sv
// Shared definitions for the x input conditioner: state encoding and default timing.
// Imported by the debouncer and available to any other front-end conditioning logic.
package debounce_pkg;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

    // Bit 1 of the encoding equals the debounced level, so x falls straight out of the state.
    typedef enum logic [1:0] {
        StIdleLow  = 2'b00,
        StWaitHigh = 2'b01,
        StIdleHigh = 2'b11,
        StWaitLow  = 2'b10
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        int unsigned w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
// Reusable for any asynchronous control input feeding the FSM.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s_q  <= 1'b0;
        end else begin
            s1_q <= d_i;
            s_q  <= s1_q;
        end
    end

    assign q_o = s_q;

endmodule

// File: rtl/x_debouncer.sv
// Debounces the raw btn_in into a clean registered level x, with one-cycle edge pulses
// and a saturating count of rejected glitches.
module x_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_in,
    output logic                x,
    output logic                x_rise,
    output logic                x_fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned CntW = cnt_width(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

    logic                s;
    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                abort;

    sync_2ff u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (btn_in),
        .q_o    (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdleLow: begin
                if (s) begin
                    state_d = StWaitHigh;
                    cnt_d   = '0;
                end
            end
            StWaitHigh: begin
                if (!s) begin
                    state_d = StIdleLow;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdleHigh;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIdleHigh: begin
                if (!s) begin
                    state_d = StWaitLow;
                    cnt_d   = '0;
                end
            end
            StWaitLow: begin
                if (s) begin
                    state_d = StIdleHigh;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdleLow;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdleLow;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturate rather than wrap so a stuck-bouncing input reads as "many", not "few".
    always_comb begin
        glitch_d = glitch_q;
        if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdleLow;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign x          = state_q[1];
    assign x_rise     = rise_q;
    assign x_fall     = fall_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_x_debouncer.sv
// Randomised and directed bench for x_debouncer against a run-length reference model.
module tb_x_debouncer;

    localparam int unsigned SC  = 4;
    localparam int unsigned GW  = 8;
    localparam int unsigned GMAX = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          btn_in = 1'b0;
    logic          x;
    logic          x_rise;
    logic          x_fall;
    logic [GW-1:0] glitch_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_rise = 0;
    int n_fall = 0;

    x_debouncer #(
        .STABLE_CYCLES (SC),
        .GLITCH_W      (GW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .x          (x),
        .x_rise     (x_rise),
        .x_fall     (x_fall),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    // Reference: x flips once the synchronized input has disagreed with x for SC+1
    // consecutive cycles; any shorter disagreement run counts as one glitch.
    logic        m_s1, m_s, m_x, m_rise, m_fall;
    int unsigned m_run, m_glitch;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1 <= 1'b0; m_s <= 1'b0; m_x <= 1'b0;
            m_rise <= 1'b0; m_fall <= 1'b0;
            m_run <= 0; m_glitch <= 0;
        end else begin
            m_s1   <= btn_in;
            m_s    <= m_s1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_s != m_x) begin
                if (m_run == SC) begin
                    m_x    <= m_s;
                    m_rise <= m_s;
                    m_fall <= ~m_s;
                    m_run  <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                if (m_run != 0 && m_glitch < GMAX) m_glitch <= m_glitch + 1;
                m_run <= 0;
            end
        end
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check_eq("x", x, m_x);
        check_eq("x_rise", x_rise, m_rise);
        check_eq("x_fall", x_fall, m_fall);
        check_eq("glitch_cnt", glitch_cnt, m_glitch);
        check_eq("pulse_excl", x_rise & x_fall, 0);
        if (x_rise) n_rise++;
        if (x_fall) n_fall++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int r0, f0, g0;

    initial begin
        // Reset, then release with btn_in low: nothing should move.
        #20 reset = 1'b1;
        cyc(5);
        check_eq("rst_x", x, 0);
        check_eq("rst_glitch", glitch_cnt, 0);
        check_eq("rst_pulses", n_rise + n_fall, 0);

        // Clean rise: x changes exactly 6 edges after the capture edge.
        r0 = n_rise; f0 = n_fall;
        btn_in = 1'b1;
        cyc(6);
        check_eq("rise_early", x, 0);
        cyc(1);
        check_eq("rise_lat", x, 1);
        check_eq("rise_pulse", x_rise, 1);
        cyc(1);
        check_eq("rise_pulse_end", x_rise, 0);
        cyc(4);
        check_eq("rise_count", n_rise - r0, 1);
        check_eq("rise_no_fall", n_fall - f0, 0);

        // Clean fall from x=1.
        g0 = glitch_cnt; f0 = n_fall;
        btn_in = 1'b0;
        cyc(6);
        check_eq("fall_early", x, 1);
        cyc(1);
        check_eq("fall_lat", x, 0);
        check_eq("fall_pulse", x_fall, 1);
        cyc(4);
        check_eq("fall_count", n_fall - f0, 1);
        check_eq("fall_glitch", glitch_cnt, g0);

        // Three-cycle high glitch from x=0 is rejected and counted.
        r0 = n_rise;
        btn_in = 1'b1;
        cyc(3);
        btn_in = 1'b0;
        cyc(10);
        check_eq("glitch3_x", x, 0);
        check_eq("glitch3_cnt", glitch_cnt, g0 + 1);
        check_eq("glitch3_rise", n_rise - r0, 0);

        // Asynchronous reset mid-WAIT_HIGH (cnt=2), released with btn_in held high.
        btn_in = 1'b1;
        cyc(5);
        #2 reset = 1'b0;
        #1;
        check_eq("async_x", x, 0);
        check_eq("async_glitch", glitch_cnt, 0);
        check_eq("async_pulses", x_rise | x_fall, 0);
        cyc(2);
        #3 reset = 1'b1;
        r0 = n_rise;
        cyc(6);
        check_eq("rel_early", x, 0);
        cyc(1);
        check_eq("rel_lat", x, 1);
        cyc(4);
        check_eq("rel_rise_count", n_rise - r0, 1);

        // Randomised segments of random level and length.
        for (int i = 0; i < 300; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 8));
        end

        // Saturation: 260 two-cycle glitches from a fresh x=0.
        btn_in = 1'b0;
        cyc(10);
        reset = 1'b0;
        #3 reset = 1'b1;
        cyc(3);
        r0 = n_rise;
        for (int i = 0; i < 260; i++) begin
            btn_in = 1'b1;
            cyc(2);
            btn_in = 1'b0;
            cyc(2);
        end
        cyc(5);
        check_eq("sat_cnt", glitch_cnt, GMAX);
        check_eq("sat_x", x, 0);
        check_eq("sat_rise", n_rise - r0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
